// File: rtl/mips_mc_ctrl_if.sv
// Control/status bundle between the multicycle MIPS controller and its datapath.
// The master side is the controller: it receives instruction fields and flags
// and drives every select, enable and ALU control.
interface mips_mc_ctrl_if #(
    parameter int unsigned STATE_W = 4
);
    logic [5:0]         op;
    logic [5:0]         funct;
    logic               zero;
    logic               mem_ready;
    logic               memread;
    logic               memwrite;
    logic               irwrite;
    logic               pcen;
    logic               iord;
    logic               regwrite;
    logic               regdst;
    logic               memtoreg;
    logic               alusrca;
    logic [1:0]         alusrcb;
    logic [1:0]         pcsrc;
    logic [3:0]         alucont;
    logic               signext;
    logic               shiftl16;
    logic               loadbyte;
    logic               illegal_op;
    logic [STATE_W-1:0] state;

    modport master (
        input  op, funct, zero, mem_ready,
        output memread, memwrite, irwrite, pcen, iord, regwrite, regdst,
               memtoreg, alusrca, alusrcb, pcsrc, alucont, signext,
               shiftl16, loadbyte, illegal_op, state
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  memread, memwrite, irwrite, pcen, iord, regwrite, regdst,
               memtoreg, alusrca, alusrcb, pcsrc, alucont, signext,
               shiftl16, loadbyte, illegal_op, state
    );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM. Sequences fetch/decode/execute over a shared
// datapath and a single-ported unified memory with a ready handshake.
// Optional macro MC_BNE_EN adds bne (op 000101) as a branch taken on ~zero;
// without it that opcode is reported as illegal.
module mips_mc_ctrl #(
    parameter int unsigned STATE_W     = 4,
    parameter int unsigned RESET_STATE = 0
) (
    input  logic           clk,
    input  logic           reset,
    mips_mc_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        RTYPEEX  = 4'd6,
        RTYPEWB  = 4'd7,
        BRANCHEX = 4'd8,
        IMMEX    = 4'd9,
        IMMWB    = 4'd10,
        JEX      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q;

    logic       op_mem, op_rtype, op_branch, op_imm, op_j, op_legal, op_lb, op_bne;
    logic       br_taken;
    logic       rt_legal;
    logic [3:0] rt_alucont;
    logic       imm_signext, imm_shift;
    logic [3:0] imm_alucont;

    logic       memread_c, memwrite_c, irwrite_c, pcen_c, iord_c, regwrite_c;
    logic       regdst_c, memtoreg_c, alusrca_c, signext_c, shiftl16_c;
    logic       loadbyte_c, illegal_c;
    logic [1:0] alusrcb_c, pcsrc_c;
    logic [3:0] alucont_c;

`ifdef MC_BNE_EN
    assign op_bne = (bus.op == OP_BNE);
`else
    assign op_bne = 1'b0;
`endif

    // Opcode class decode shared by next-state and output logic
    always_comb begin
        op_mem    = (bus.op == OP_LW) || (bus.op == OP_LB) || (bus.op == OP_SW);
        op_rtype  = (bus.op == OP_RTYPE);
        op_branch = (bus.op == OP_BEQ) || op_bne;
        op_imm    = (bus.op == OP_ADDI) || (bus.op == OP_SLTI) ||
                    (bus.op == OP_ORI)  || (bus.op == OP_LUI);
        op_j      = (bus.op == OP_J);
        op_legal  = op_mem || op_rtype || op_branch || op_imm || op_j;
        op_lb     = (bus.op == OP_LB);
        br_taken  = ((bus.op == OP_BEQ) && bus.zero) || (op_bne && !bus.zero);
    end

    // R-type funct to ALU control, flagging unsupported functs
    always_comb begin
        rt_legal   = 1'b1;
        rt_alucont = 4'b0000;
        case (bus.funct)
            6'b100000: rt_alucont = 4'b0010;
            6'b100010: rt_alucont = 4'b0110;
            6'b100100: rt_alucont = 4'b0000;
            6'b100101: rt_alucont = 4'b0001;
            6'b101010: rt_alucont = 4'b0111;
            default:   rt_legal   = 1'b0;
        endcase
    end

    // Immediate-op extension, shift and ALU control (held through write-back)
    always_comb begin
        imm_signext = (bus.op == OP_ADDI) || (bus.op == OP_SLTI);
        imm_shift   = (bus.op == OP_LUI);
        imm_alucont = 4'b0010;
        if (bus.op == OP_SLTI)
            imm_alucont = 4'b0111;
        else if ((bus.op == OP_ORI) || (bus.op == OP_LUI))
            imm_alucont = 4'b0001;
    end

    // State register and transitions; memory states hold until mem_ready
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= state_t'(4'(RESET_STATE));
        end else begin
            case (state_q)
                FETCH:    if (bus.mem_ready) state_q <= DECODE;
                DECODE: begin
                    if (op_mem)         state_q <= MEMADR;
                    else if (op_rtype)  state_q <= RTYPEEX;
                    else if (op_branch) state_q <= BRANCHEX;
                    else if (op_imm)    state_q <= IMMEX;
                    else if (op_j)      state_q <= JEX;
                    else                state_q <= FETCH;
                end
                MEMADR:   state_q <= (bus.op == OP_SW) ? MEMWR : MEMRD;
                MEMRD:    if (bus.mem_ready) state_q <= MEMWB;
                MEMWR:    if (bus.mem_ready) state_q <= FETCH;
                RTYPEEX:  state_q <= rt_legal ? RTYPEWB : FETCH;
                IMMEX:    state_q <= IMMWB;
                default:  state_q <= FETCH;
            endcase
        end
    end

    // Moore output decode from the current state and instruction fields
    always_comb begin
        memread_c  = 1'b0;
        memwrite_c = 1'b0;
        irwrite_c  = 1'b0;
        pcen_c     = 1'b0;
        iord_c     = 1'b0;
        regwrite_c = 1'b0;
        regdst_c   = 1'b0;
        memtoreg_c = 1'b0;
        alusrca_c  = 1'b0;
        alusrcb_c  = '0;
        pcsrc_c    = '0;
        alucont_c  = '0;
        signext_c  = 1'b0;
        shiftl16_c = 1'b0;
        loadbyte_c = 1'b0;
        illegal_c  = 1'b0;
        case (state_q)
            FETCH: begin
                memread_c = 1'b1;
                alusrcb_c = 2'b01;
                alucont_c = 4'b0010;
                irwrite_c = bus.mem_ready;
                pcen_c    = bus.mem_ready;
            end
            DECODE: begin
                alusrcb_c = 2'b11;
                alucont_c = 4'b0010;
                signext_c = 1'b1;
                illegal_c = !op_legal;
            end
            MEMADR: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                alucont_c = 4'b0010;
                signext_c = 1'b1;
            end
            MEMRD: begin
                memread_c  = 1'b1;
                iord_c     = 1'b1;
                loadbyte_c = op_lb;
            end
            MEMWB: begin
                regwrite_c = 1'b1;
                memtoreg_c = 1'b1;
                loadbyte_c = op_lb;
            end
            MEMWR: begin
                memwrite_c = 1'b1;
                iord_c     = 1'b1;
            end
            RTYPEEX: begin
                alusrca_c = 1'b1;
                alucont_c = rt_alucont;
                illegal_c = !rt_legal;
            end
            RTYPEWB: begin
                regwrite_c = 1'b1;
                regdst_c   = 1'b1;
            end
            BRANCHEX: begin
                alusrca_c = 1'b1;
                alucont_c = 4'b0110;
                pcsrc_c   = 2'b01;
                pcen_c    = br_taken;
            end
            IMMEX: begin
                alusrca_c  = 1'b1;
                alusrcb_c  = 2'b10;
                alucont_c  = imm_alucont;
                signext_c  = imm_signext;
                shiftl16_c = imm_shift;
            end
            IMMWB: begin
                regwrite_c = 1'b1;
                signext_c  = imm_signext;
                shiftl16_c = imm_shift;
            end
            JEX: begin
                pcsrc_c = 2'b10;
                pcen_c  = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset low suppresses every output immediately, so an abandoned
    // instruction cannot issue a write on the reset cycle.
    assign bus.memread    = reset & memread_c;
    assign bus.memwrite   = reset & memwrite_c;
    assign bus.irwrite    = reset & irwrite_c;
    assign bus.pcen       = reset & pcen_c;
    assign bus.iord       = reset & iord_c;
    assign bus.regwrite   = reset & regwrite_c;
    assign bus.regdst     = reset & regdst_c;
    assign bus.memtoreg   = reset & memtoreg_c;
    assign bus.alusrca    = reset & alusrca_c;
    assign bus.alusrcb    = reset ? alusrcb_c : '0;
    assign bus.pcsrc      = reset ? pcsrc_c : '0;
    assign bus.alucont    = reset ? alucont_c : '0;
    assign bus.signext    = reset & signext_c;
    assign bus.shiftl16   = reset & shiftl16_c;
    assign bus.loadbyte   = reset & loadbyte_c;
    assign bus.illegal_op = reset & illegal_c;
    assign bus.state      = reset ? STATE_W'(state_q) : '0;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: walks each instruction class through its
// state sequence and checks state and control outputs against hand-written
// control words. Inputs change 1 time unit after the rising edge; outputs
// are sampled 1 time unit later.
module tb_mips_mc_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    mips_mc_ctrl_if #(.STATE_W(4)) bus ();

    mips_mc_ctrl #(.STATE_W(4), .RESET_STATE(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Order: memread memwrite irwrite pcen iord regwrite regdst memtoreg
    //        alusrca alusrcb[2] pcsrc[2] alucont[4] signext shiftl16 loadbyte illegal_op
    logic [20:0] ctl;
    assign ctl = {bus.memread, bus.memwrite, bus.irwrite, bus.pcen, bus.iord,
                  bus.regwrite, bus.regdst, bus.memtoreg, bus.alusrca,
                  bus.alusrcb, bus.pcsrc, bus.alucont, bus.signext,
                  bus.shiftl16, bus.loadbyte, bus.illegal_op};

    function automatic logic [20:0] cw(
        input logic mr, input logic mw, input logic ir, input logic pe,
        input logic io, input logic rw, input logic rd, input logic mtr,
        input logic asa, input logic [1:0] asb, input logic [1:0] pcs,
        input logic [3:0] ac, input logic se, input logic sl,
        input logic lb, input logic il);
        return {mr, mw, ir, pe, io, rw, rd, mtr, asa, asb, pcs, ac, se, sl, lb, il};
    endfunction

    localparam logic [20:0] CW_DEC = 21'b0_0_0_0_0_0_0_0_0_11_00_0010_1_0_0_0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Completes a FETCH with memory ready and lands in DECODE
    task automatic fetch(input logic [5:0] op, input logic [5:0] funct);
        bus.op        = op;
        bus.funct     = funct;
        bus.mem_ready = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        reset         = 1'b0;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            #1;
            if (ctl !== 21'd0) begin
                $display("FAIL reset_ctl[%0d]: got %b want %b", i, ctl, 21'd0);
                n_err++;
            end
            n_cmp++;
            if (bus.state !== 4'd0) begin
                $display("FAIL reset_state[%0d]: got %0d want 0", i, bus.state);
                n_err++;
            end
            n_cmp++;
        end
        reset         = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        if (ctl !== cw(1,0,0,0,0,0,0,0,0,2'b01,2'b00,4'b0010,0,0,0,0)) begin
            $display("FAIL fetch_wait_ctl: got %b", ctl);
            n_err++;
        end
        n_cmp++;
        tick;
        if (bus.state !== 4'd0) begin
            $display("FAIL fetch_hold_state: got %0d want 0", bus.state);
            n_err++;
        end
        n_cmp++;
        bus.mem_ready = 1'b1;
        #1;
        if (ctl !== cw(1,0,1,1,0,0,0,0,0,2'b01,2'b00,4'b0010,0,0,0,0)) begin
            $display("FAIL fetch_ready_ctl: got %b", ctl);
            n_err++;
        end
        n_cmp++;
        bus.op = 6'b000010;
        tick;
        if (bus.state !== 4'd1) begin
            $display("FAIL first_decode_state: got %0d want 1", bus.state);
            n_err++;
        end
        n_cmp++;
        tick;
        tick;
    endtask

    task automatic test_loads;
        int exp_st[11] = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 4, 0};
        logic rdy[11]  = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 0};
        bus.op    = 6'b100011;
        bus.funct = 6'b000000;
        for (int i = 0; i < 11; i++) begin
            bus.mem_ready = rdy[i];
            #1;
            if (bus.state !== 4'(exp_st[i])) begin
                $display("FAIL lw_state[%0d]: got %0d want %0d", i, bus.state, exp_st[i]);
                n_err++;
            end
            n_cmp++;
            if (bus.regwrite !== (exp_st[i] == 4)) begin
                $display("FAIL lw_regwrite[%0d]: got %b want %b", i, bus.regwrite, exp_st[i] == 4);
                n_err++;
            end
            n_cmp++;
            if (exp_st[i] == 3) begin
                if ({bus.memread, bus.memwrite, bus.iord} !== 3'b101) begin
                    $display("FAIL lw_memrd[%0d]: got %b want 101", i, {bus.memread, bus.memwrite, bus.iord});
                    n_err++;
                end
                n_cmp++;
            end
            if (exp_st[i] == 4) begin
                if (bus.memtoreg !== 1'b1) begin
                    $display("FAIL lw_memtoreg: got %b want 1", bus.memtoreg);
                    n_err++;
                end
                n_cmp++;
            end
            tick;
        end
        fetch(6'b100000, 6'b000000);
        tick;
        tick;
        if (ctl !== cw(1,0,0,0,1,0,0,0,0,2'b00,2'b00,4'b0000,0,0,1,0)) begin
            $display("FAIL lb_memrd_ctl: got %b", ctl);
            n_err++;
        end
        n_cmp++;
        tick;
        if (ctl !== cw(0,0,0,0,0,1,0,1,0,2'b00,2'b00,4'b0000,0,0,1,0)) begin
            $display("FAIL lb_memwb_ctl: got %b", ctl);
            n_err++;
        end
        n_cmp++;
        tick;
    endtask

    task automatic test_rtype;
        logic [5:0] fn[4] = '{6'b100000, 6'b100100, 6'b100101, 6'b101010};
        logic [3:0] ac[4] = '{4'b0010, 4'b0000, 4'b0001, 4'b0111};
        fetch(6'b000000, 6'b100010);
        if (bus.state !== 4'd1 || ctl !== CW_DEC) begin
            $display("FAIL sub_decode: got state %0d ctl %b", bus.state, ctl);
            n_err++;
        end
        n_cmp++;
        tick;
        if (bus.state !== 4'd6 || ctl !== cw(0,0,0,0,0,0,0,0,1,2'b00,2'b00,4'b0110,0,0,0,0)) begin
            $display("FAIL sub_rtypeex: got state %0d ctl %b", bus.state, ctl);
            n_err++;
        end
        n_cmp++;
        tick;
        if (bus.state !== 4'd7 || ctl !== cw(0,0,0,0,0,1,1,0,0,2'b00,2'b00,4'b0000,0,0,0,0)) begin
            $display("FAIL sub_rtypewb: got state %0d ctl %b", bus.state, ctl);
            n_err++;
        end
        n_cmp++;
        tick;
        if (bus.state !== 4'd0) begin
            $display("FAIL sub_return: got %0d want 0", bus.state);
            n_err++;
        end
        n_cmp++;
        for (int i = 0; i < 4; i++) begin
            fetch(6'b000000, fn[i]);
            tick;
            if (bus.alucont !== ac[i]) begin
                $display("FAIL funct_alucont[%0d]: got %b want %b", i, bus.alucont, ac[i]);
                n_err++;
            end
            n_cmp++;
            tick;
            tick;
        end
        fetch(6'b000000, 6'b000111);
        tick;
        if (bus.state !== 4'd6 || bus.illegal_op !== 1'b1 || bus.regwrite !== 1'b0) begin
            $display("FAIL bad_funct_ex: got state %0d illegal %b regwrite %b", bus.state, bus.illegal_op, bus.regwrite);
            n_err++;
        end
        n_cmp++;
        tick;
        if (bus.state !== 4'd0 || bus.regwrite !== 1'b0 || bus.illegal_op !== 1'b0) begin
            $display("FAIL bad_funct_ret: got state %0d regwrite %b illegal %b", bus.state, bus.regwrite, bus.illegal_op);
            n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_branch;
        for (int z = 1; z >= 0; z--) begin
            bus.zero = z[0];
            fetch(6'b000100, 6'b000000);
            tick;
            if (bus.state !== 4'd8 || ctl !== cw(0,0,0,z[0],0,0,0,0,1,2'b00,2'b01,4'b0110,0,0,0,0)) begin
                $display("FAIL beq_z%0d: got state %0d ctl %b", z, bus.state, ctl);
                n_err++;
            end
            n_cmp++;
            tick;
            if (bus.state !== 4'd0) begin
                $display("FAIL beq_z%0d_return: got %0d want 0", z, bus.state);
                n_err++;
            end
            n_cmp++;
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_imm_jump;
        logic [5:0]  ops[4]  = '{6'b001111, 6'b001101, 6'b001010, 6'b001000};
        logic [20:0] ex_w[4] = '{cw(0,0,0,0,0,0,0,0,1,2'b10,2'b00,4'b0001,0,1,0,0),
                                 cw(0,0,0,0,0,0,0,0,1,2'b10,2'b00,4'b0001,0,0,0,0),
                                 cw(0,0,0,0,0,0,0,0,1,2'b10,2'b00,4'b0111,1,0,0,0),
                                 cw(0,0,0,0,0,0,0,0,1,2'b10,2'b00,4'b0010,1,0,0,0)};
        logic [20:0] wb_w[4] = '{cw(0,0,0,0,0,1,0,0,0,2'b00,2'b00,4'b0000,0,1,0,0),
                                 cw(0,0,0,0,0,1,0,0,0,2'b00,2'b00,4'b0000,0,0,0,0),
                                 cw(0,0,0,0,0,1,0,0,0,2'b00,2'b00,4'b0000,1,0,0,0),
                                 cw(0,0,0,0,0,1,0,0,0,2'b00,2'b00,4'b0000,1,0,0,0)};
        for (int i = 0; i < 4; i++) begin
            fetch(ops[i], 6'b000000);
            tick;
            if (bus.state !== 4'd9 || ctl !== ex_w[i]) begin
                $display("FAIL imm_ex[%0d]: got state %0d ctl %b want %b", i, bus.state, ctl, ex_w[i]);
                n_err++;
            end
            n_cmp++;
            tick;
            if (bus.state !== 4'd10 || ctl !== wb_w[i]) begin
                $display("FAIL imm_wb[%0d]: got state %0d ctl %b want %b", i, bus.state, ctl, wb_w[i]);
                n_err++;
            end
            n_cmp++;
            tick;
        end
        fetch(6'b000010, 6'b000000);
        tick;
        if (bus.state !== 4'd11 || ctl !== cw(0,0,0,1,0,0,0,0,0,2'b00,2'b10,4'b0000,0,0,0,0)) begin
            $display("FAIL j_jex: got state %0d ctl %b", bus.state, ctl);
            n_err++;
        end
        n_cmp++;
        tick;
        if (bus.state !== 4'd0) begin
            $display("FAIL j_return: got %0d want 0", bus.state);
            n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_illegal_op;
        fetch(6'b111111, 6'b000000);
        if (bus.state !== 4'd1 || ctl !== (CW_DEC | 21'd1)) begin
            $display("FAIL illegal_decode: got state %0d ctl %b", bus.state, ctl);
            n_err++;
        end
        n_cmp++;
        tick;
        if (bus.state !== 4'd0 || bus.illegal_op !== 1'b0) begin
            $display("FAIL illegal_return: got state %0d illegal %b", bus.state, bus.illegal_op);
            n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_reset_midwrite;
        fetch(6'b101011, 6'b000000);
        bus.mem_ready = 1'b0;
        tick;
        if (bus.state !== 4'd2 || ctl !== cw(0,0,0,0,0,0,0,0,1,2'b10,2'b00,4'b0010,1,0,0,0)) begin
            $display("FAIL sw_memadr: got state %0d ctl %b", bus.state, ctl);
            n_err++;
        end
        n_cmp++;
        tick;
        if (bus.state !== 4'd5 || ctl !== cw(0,1,0,0,1,0,0,0,0,2'b00,2'b00,4'b0000,0,0,0,0)) begin
            $display("FAIL sw_memwr: got state %0d ctl %b", bus.state, ctl);
            n_err++;
        end
        n_cmp++;
        tick;
        if (bus.state !== 4'd5 || bus.memwrite !== 1'b1) begin
            $display("FAIL sw_memwr_hold: got state %0d memwrite %b", bus.state, bus.memwrite);
            n_err++;
        end
        n_cmp++;
        reset = 1'b0;
        #1;
        if (ctl !== 21'd0 || bus.state !== 4'd0) begin
            $display("FAIL reset_force: got state %0d ctl %b", bus.state, ctl);
            n_err++;
        end
        n_cmp++;
        tick;
        reset = 1'b1;
        #1;
        if (bus.state !== 4'd0 || bus.memwrite !== 1'b0 || bus.memread !== 1'b1) begin
            $display("FAIL reset_midwrite: got state %0d memwrite %b memread %b", bus.state, bus.memwrite, bus.memread);
            n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_bne;
        bus.zero = 1'b0;
        fetch(6'b000101, 6'b000000);
`ifdef MC_BNE_EN
        if (bus.illegal_op !== 1'b0) begin
            $display("FAIL bne_decode: got illegal %b want 0", bus.illegal_op);
            n_err++;
        end
        n_cmp++;
        tick;
        if (bus.state !== 4'd8 || bus.pcen !== 1'b1) begin
            $display("FAIL bne_taken: got state %0d pcen %b", bus.state, bus.pcen);
            n_err++;
        end
        n_cmp++;
        tick;
`else
        if (bus.illegal_op !== 1'b1) begin
            $display("FAIL bne_illegal: got illegal %b want 1", bus.illegal_op);
            n_err++;
        end
        n_cmp++;
        tick;
        if (bus.state !== 4'd0) begin
            $display("FAIL bne_return: got %0d want 0", bus.state);
            n_err++;
        end
        n_cmp++;
`endif
    endtask

    initial begin
        reset         = 1'b0;
        bus.op        = '0;
        bus.funct     = '0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        test_reset;
        test_loads;
        test_rtype;
        test_branch;
        test_imm_jump;
        test_illegal_op;
        test_reset_midwrite;
        test_bne;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
Multicycle control FSM that sequences the shared MIPS datapath: register file, ALU, adder, sl2, sign_zero_ext, shift_left_16, byte_addr/word_to_byte, flopenr and mux2 instances. One instruction takes 3-5 states, plus any memory wait states. It decodes op/funct and drives every mux select, enable and ALU control. It stalls on a single-ported unified memory through a ready handshake.

Parameters:
STATE_W, 4, width of the state register and debug state port
RESET_STATE, 0, state code entered on reset (FETCH)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset; sampled on rising clk
op  in  6  instr[31:26] from instruction register
funct  in  6  instr[5:0] from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory has completed the current access this cycle
memread  out  1  memory read request
memwrite  out  1  memory write request
irwrite  out  1  load instruction register
pcen  out  1  PC flop enable = pcwrite | (branch & branch-condition)
iord  out  1  memory address select: 0 PC, 1 ALUOut
regwrite  out  1  register file write enable
regdst  out  1  write address select: 0 rt, 1 rd
memtoreg  out  1  write data select: 0 ALUOut, 1 memory data register
alusrca  out  1  ALU A select: 0 PC, 1 register A
alusrcb  out  2  ALU B select: 00 reg B, 01 const 4, 10 ext imm, 11 ext imm<<2
pcsrc  out  2  next PC select: 00 ALU result, 01 ALUOut, 10 jump target
alucont  out  4  [3] invert A, [2] invert B with +1, [1:0] 00 AND, 01 OR, 10 SUM, 11 SLT
signext  out  1  1 sign-extend immediate, 0 zero-extend
shiftl16  out  1  immediate shifted left by 16 (lui)
loadbyte  out  1  byte address/extract path active (lb)
illegal_op  out  1  one-cycle pulse on an unsupported op/funct
state  out  STATE_W  current state, for debug

Behaviour:
- Reset: reset==0 at a clock edge puts the FSM in FETCH. While reset is low, all outputs are forced 0 combinationally and state reads 0. Reset may arrive mid-instruction; the instruction is abandoned with no partial writes.
- States: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BRANCHEX 8, IMMEX 9, IMMWB 10, JEX 11.
- FETCH:
  - Outputs: memread=1, iord=0, alusrca=0, alusrcb=01, alucont=0010, pcsrc=00.
  - irwrite and pcen are asserted only in the cycle mem_ready=1; that cycle advances to DECODE.
  - Stay in FETCH while mem_ready=0.
- DECODE: alusrca=0, alusrcb=11, alucont=0010, signext=1 (branch target into ALUOut). Next state by op:
  - lw 100011, lb 100000, sw 101011 -> MEMADR
  - R-type 000000 -> RTYPEEX
  - beq 000100 -> BRANCHEX
  - addi 001000, slti 001010, ori 001101, lui 001111 -> IMMEX
  - j 000010 -> JEX
  - any other op -> illegal_op=1 for this cycle, next FETCH
- MEMADR: alusrca=1, alusrcb=10, signext=1, alucont=0010. Next MEMWR for sw, otherwise MEMRD.
- MEMRD: memread=1, iord=1, loadbyte=(op==lb). Wait for mem_ready, then MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=1, loadbyte=(op==lb). Next FETCH.
- MEMWR: memwrite=1, iord=1. Wait for mem_ready, then FETCH. memwrite stays high and stable until the ready cycle.
- RTYPEEX: alusrca=1, alusrcb=00. alucont from funct:
  - add 100000 -> 0010, sub 100010 -> 0110, and 100100 -> 0000, or 100101 -> 0001, slt 101010 -> 0111
  - other funct -> illegal_op pulse, next FETCH, no write
- RTYPEWB: regwrite=1, regdst=1, memtoreg=0. Next FETCH.
- BRANCHEX: alusrca=1, alusrcb=00, alucont=0110, pcsrc=01. pcen=zero for beq. Next FETCH.
- IMMEX: alusrca=1, alusrcb=10. Per op:
  - addi: alucont=0010, signext=1
  - slti: alucont=0111, signext=1
  - ori: alucont=0001, signext=0
  - lui: alucont=0001, signext=0, shiftl16=1 (A selected as reg A, which holds $0 for lui)
  - Next IMMWB.
- IMMWB: regwrite=1, regdst=0, memtoreg=0, plus the same ext/shift controls as IMMEX. Next FETCH.
- JEX: pcsrc=10, pcen=1. Next FETCH.
- Outputs are Moore-decoded from state and op/funct. The only dependence on mem_ready/zero is pcen, irwrite and state advance.
- memread and memwrite are never high in the same cycle.
- regwrite is asserted at most once per instruction.
- Latency without waits, in cycles: lw/lb 5, sw 4, R-type 4, imm 4, beq 3, j 3.

Optional Feature:
MC_BNE_EN
- Defined: op 000101 (bne) decodes to BRANCHEX with pcen=~zero; beq behaviour is unchanged.
- Undefined: 000101 is illegal (illegal_op pulse in DECODE, next FETCH).

Test Plan:
- Hold reset=0 for 3 clocks with mem_ready=1 -> all outputs 0 and state=0. Release reset -> FETCH shows memread=1, and the first edge with mem_ready=1 pulses irwrite and pcen.
- lw with mem_ready low 2 cycles in FETCH and 3 cycles in MEMRD -> state sequence 0,0,0,1,2,3,3,3,3,4,0. regwrite high only in state 4, with memtoreg=1.
- R-type sub (funct 100010) -> alucont=0110 in RTYPEEX; RTYPEWB has regwrite=1, regdst=1. Funct 000111 -> illegal_op pulse, no regwrite, back to FETCH.
- beq with zero=1 -> pcen=1 and pcsrc=01 in BRANCHEX. With zero=0 -> pcen=0; both return to FETCH after 3 cycles.
- lui -> IMMEX/IMMWB with shiftl16=1, signext=0, alucont=0001. ori -> signext=0, shiftl16=0. slti -> alucont=0111, signext=1.
- Drive reset=0 while in MEMWR with memwrite=1 -> the next edge gives state=0 and memwrite=0. With MC_BNE_EN: bne with zero=0 -> pcen=1; without it, bne -> illegal_op pulse.
